// File: rtl/care_scheduler.sv
// care_scheduler: round-robin care action sequencer for the stats block.
// Also generates the decay tick and the 0-5 random stat selector.
module care_scheduler #(
  parameter int TICK_PERIOD    = 27_000_000,
  parameter int STEPS          = 4,
  parameter int GAP_CYCLES     = 2_700_000,
  parameter int COOLDOWN_TICKS = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] req_i,
  input  logic       pause_i,
  output logic [7:0] act_o,
  output logic       tick_o,
  output logic [2:0] rand_o,
  output logic       busy_o,
  output logic [2:0] active_o,
  output logic [5:0] cooldown_o,
  output logic       drop_o
);

  localparam int TW = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
  localparam int SW = (STEPS > 1) ? $clog2(STEPS + 1) : 1;
  localparam int GW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES - 1) : 1;
  localparam int CW = $clog2(COOLDOWN_TICKS + 1);

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    GAP
  } state_t;

  state_t          state_q, state_d;
  logic [5:0]      pending_q;
  logic [2:0]      last_q;
  logic [2:0]      active_q;
  logic [SW-1:0]   step_q;
  logic [GW-1:0]   gap_q;
  logic [TW-1:0]   tick_cnt_q;
  logic [7:0]      lfsr_q;
  logic [2:0]      rand_q;
  logic [CW-1:0]   cd_q [6];
  logic            drop_q;

  logic            tick;
  logic            busy;
  logic            grant;
  logic            finish;
  logic            grant_valid;
  logic [2:0]      grant_idx;
  logic [5:0]      grant_mask;
  logic [5:0]      active_mask;
  logic [5:0]      cool;
  logic [5:0]      eligible;
  logic [2:0]      lsel;

  assign tick = (tick_cnt_q == TW'(TICK_PERIOD - 1)) && !pause_i;
  assign busy = (state_q != IDLE);
  assign lsel = lfsr_q[2:0];

  always_comb begin
    cool        = '0;
    active_mask = '0;
    for (int i = 0; i < 6; i++) begin
      cool[i]        = (cd_q[i] != '0);
      active_mask[i] = busy && (active_q == 3'(i));
    end
  end

  assign eligible = ~cool & ~pending_q & ~active_mask;

  // Search starts just after the last granted index and wraps.
  always_comb begin
    int j;
    j           = 0;
    grant_valid = 1'b0;
    grant_idx   = 3'd0;
    for (int k = 1; k <= 6; k++) begin
      j = (int'(last_q) + k) % 6;
      if (!grant_valid && pending_q[j]) begin
        grant_valid = 1'b1;
        grant_idx   = 3'(j);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_valid && !pause_i) begin
          grant   = 1'b1;
          state_d = APPLY;
        end
      end
      APPLY: begin
        if (step_q == SW'(STEPS - 1)) begin
          finish  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = GAP;
        end
      end
      GAP: begin
        if (gap_q == GW'(GAP_CYCLES - 2)) state_d = APPLY;
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant_mask = grant ? (6'b000001 << grant_idx) : 6'b000000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      last_q    <= 3'd5;
      active_q  <= 3'd0;
      step_q    <= '0;
      gap_q     <= '0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= (pending_q | (req_i & eligible)) & ~grant_mask;
      drop_q    <= |(req_i & ~eligible);
      if (grant) begin
        last_q   <= grant_idx;
        active_q <= grant_idx;
        step_q   <= '0;
      end else if (state_q == APPLY) begin
        step_q <= step_q + 1'b1;
      end
      if (state_q == APPLY) gap_q <= '0;
      else if (state_q == GAP) gap_q <= gap_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
      lfsr_q     <= 8'hA5;
      rand_q     <= 3'd0;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      if (!pause_i) begin
        if (tick_cnt_q == TW'(TICK_PERIOD - 1)) tick_cnt_q <= '0;
        else tick_cnt_q <= tick_cnt_q + 1'b1;
      end
      if (tick) rand_q <= (lsel >= 3'd6) ? lsel - 3'd6 : lsel;
    end
  end

  // A completing burst reloads its cooldown even on a tick cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 6; i++) cd_q[i] <= '0;
    end else begin
      for (int i = 0; i < 6; i++) begin
        if (finish && active_q == 3'(i)) cd_q[i] <= CW'(COOLDOWN_TICKS);
        else if (tick && cd_q[i] != '0) cd_q[i] <= cd_q[i] - 1'b1;
      end
    end
  end

  always_comb begin
    act_o = 8'h00;
    for (int i = 0; i < 6; i++) begin
      act_o[i] = (state_q == APPLY) && (active_q == 3'(i));
    end
  end

  assign tick_o     = tick;
  assign rand_o     = rand_q;
  assign busy_o     = busy;
  assign active_o   = active_q;
  assign cooldown_o = cool;
  assign drop_o     = drop_q;

endmodule

// File: tb/tb_care_scheduler.sv
// tb_care_scheduler: directed scenario bench for care_scheduler.
// Inputs change and outputs are sampled at the falling edge.
module tb_care_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] req;
  logic       pause;
  logic [7:0] act;
  logic       tick;
  logic [2:0] rnd;
  logic       busy;
  logic [2:0] active;
  logic [5:0] cooldown;
  logic       drop;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  care_scheduler #(
    .TICK_PERIOD   (10),
    .STEPS         (3),
    .GAP_CYCLES    (4),
    .COOLDOWN_TICKS(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req),
    .pause_i   (pause),
    .act_o     (act),
    .tick_o    (tick),
    .rand_o    (rnd),
    .busy_o    (busy),
    .active_o  (active),
    .cooldown_o(cooldown),
    .drop_o    (drop)
  );

  // Leaves the bench in the first cycle after release (t=0).
  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    pause = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    int first;
    do_reset();
    total++;
    if (act !== 8'h00) $display("FAIL reset_act got %h want 00", act);
    else passed++;
    total++;
    if (tick !== 1'b0) $display("FAIL reset_tick got %b want 0", tick);
    else passed++;
    total++;
    if (rnd !== 3'd0) $display("FAIL reset_rand got %0d want 0", rnd);
    else passed++;
    total++;
    if (cooldown !== 6'b0) $display("FAIL reset_cd got %b want 0", cooldown);
    else passed++;
    total++;
    if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy);
    else passed++;
    total++;
    if (drop !== 1'b0) $display("FAIL reset_drop got %b want 0", drop);
    else passed++;
    total++;
    if (active !== 3'd0) $display("FAIL reset_active got %0d want 0", active);
    else passed++;
    first = 0;
    for (int c = 1; c <= 30 && first == 0; c++) begin
      if (tick === 1'b1) first = c;
      @(negedge clk);
    end
    total++;
    if (first != 10) $display("FAIL first_tick got cycle %0d want 10", first);
    else passed++;
  endtask

  task automatic test_single();
    logic [7:0] exp_act;
    int ticks;
    int n;
    do_reset();
    req = 6'b000001;
    @(negedge clk);
    req = '0;
    for (int t = 1; t <= 10; t++) begin
      exp_act = (t == 2 || t == 6 || t == 10) ? 8'h01 : 8'h00;
      total++;
      if (act !== exp_act) $display("FAIL single_act t=%0d got %h want %h", t, act, exp_act);
      else passed++;
      total++;
      if (busy !== (t >= 2)) $display("FAIL single_busy t=%0d got %b want %b", t, busy, t >= 2);
      else passed++;
      @(negedge clk);
    end
    total++;
    if (busy !== 1'b0 || act !== 8'h00)
      $display("FAIL single_end got busy=%b act=%h want 0/00", busy, act);
    else passed++;
    total++;
    if (cooldown !== 6'b000001) $display("FAIL single_cd got %b want 000001", cooldown);
    else passed++;
    ticks = 0;
    n = 0;
    while (cooldown[0] === 1'b1 && n < 60) begin
      if (tick === 1'b1) ticks++;
      @(negedge clk);
      n++;
    end
    total++;
    if (cooldown[0] !== 1'b0 || ticks != 2)
      $display("FAIL single_cd_ticks got cd=%b ticks=%0d want 0/2", cooldown[0], ticks);
    else passed++;
  endtask

  task automatic test_simul();
    logic [7:0] exp_act;
    do_reset();
    req = 6'b000110;
    @(negedge clk);
    req = '0;
    for (int t = 1; t <= 22; t++) begin
      exp_act = (t == 2 || t == 6 || t == 10) ? 8'h02 :
                (t == 12 || t == 16 || t == 20) ? 8'h04 : 8'h00;
      total++;
      if (act !== exp_act) $display("FAIL simul_act t=%0d got %h want %h", t, act, exp_act);
      else passed++;
      if (t == 2) begin
        total++;
        if (active !== 3'd1) $display("FAIL simul_active1 got %0d want 1", active);
        else passed++;
      end
      if (t == 11) begin
        total++;
        if (busy !== 1'b0) $display("FAIL simul_idle_gap got busy=%b want 0", busy);
        else passed++;
      end
      if (t == 12) begin
        total++;
        if (active !== 3'd2) $display("FAIL simul_active2 got %0d want 2", active);
        else passed++;
      end
      if (t == 21) begin
        total++;
        if (cooldown !== 6'b000110) $display("FAIL simul_cd got %b want 000110", cooldown);
        else passed++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_cooldown();
    logic [7:0] exp_act;
    int n;
    do_reset();
    for (int t = 0; t <= 16; t++) begin
      if (t >= 1) begin
        exp_act = (t == 2 || t == 6 || t == 10) ? 8'h01 : 8'h00;
        total++;
        if (act !== exp_act) $display("FAIL cd_act t=%0d got %h want %h", t, act, exp_act);
        else passed++;
      end
      if (t == 1 || t == 5 || t == 13) begin
        total++;
        if (drop !== (t != 1)) $display("FAIL cd_drop t=%0d got %b want %b", t, drop, t != 1);
        else passed++;
      end
      if (t == 11) begin
        total++;
        if (cooldown !== 6'b000001) $display("FAIL cd_set got %b want 000001", cooldown);
        else passed++;
      end
      req = (t == 0 || t == 4 || t == 12) ? 6'b000001 : 6'b000000;
      @(negedge clk);
    end
    n = 0;
    while (cooldown[0] === 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (cooldown !== 6'b0) $display("FAIL cd_clear got %b want 0", cooldown);
    else passed++;
    req = 6'b000001;
    @(negedge clk);
    req = '0;
    total++;
    if (drop !== 1'b0) $display("FAIL cd_reaccept_drop got %b want 0", drop);
    else passed++;
    @(negedge clk);
    total++;
    if (act !== 8'h01) $display("FAIL cd_reaccept_act got %h want 01", act);
    else passed++;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_pause();
    logic [7:0] exp_act;
    do_reset();
    for (int t = 0; t <= 32; t++) begin
      if (t >= 1) begin
        exp_act = (t == 2 || t == 6 || t == 10) ? 8'h08 :
                  (t == 32) ? 8'h10 : 8'h00;
        total++;
        if (act !== exp_act) $display("FAIL pause_act t=%0d got %h want %h", t, act, exp_act);
        else passed++;
      end
      if (t >= 5 && t <= 30) begin
        total++;
        if (tick !== 1'b0) $display("FAIL pause_tick t=%0d got %b want 0", t, tick);
        else passed++;
      end
      if (t == 11 || t == 30) begin
        total++;
        if (cooldown !== 6'b001000) $display("FAIL pause_cd t=%0d got %b want 001000", t, cooldown);
        else passed++;
      end
      if (t == 13) begin
        total++;
        if (drop !== 1'b0) $display("FAIL pause_req_drop got %b want 0", drop);
        else passed++;
      end
      if (t == 32) begin
        total++;
        if (active !== 3'd4) $display("FAIL pause_grant got %0d want 4", active);
        else passed++;
      end
      req   = (t == 0) ? 6'b001000 : (t == 12) ? 6'b010000 : 6'b000000;
      pause = (t >= 4 && t <= 30);
      @(negedge clk);
    end
    pause = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset_gap();
    logic [7:0] exp_act;
    logic [7:0] seen;
    int bad;
    int ticks;
    int hits;
    do_reset();
    for (int t = 0; t <= 35; t++) begin
      if (t >= 1) begin
        exp_act = (t == 2 || t == 6 || t == 10) ? 8'h01 :
                  (t == 13) ? 8'h04 : 8'h00;
        total++;
        if (act !== exp_act) $display("FAIL rgap_act t=%0d got %h want %h", t, act, exp_act);
        else passed++;
      end
      if (t == 14) begin
        total++;
        if (cooldown !== 6'b000001) $display("FAIL rgap_pre_cd got %b want 000001", cooldown);
        else passed++;
      end
      if (t == 16 || t == 30) begin
        total++;
        if (cooldown !== 6'b0 || busy !== 1'b0)
          $display("FAIL rgap_cleared t=%0d got cd=%b busy=%b want 0/0", t, cooldown, busy);
        else passed++;
      end
      req   = (t == 0)  ? 6'b000001 :
              (t == 11) ? 6'b000100 :
              (t == 12) ? 6'b100000 : 6'b000000;
      rst_n = !(t == 15 || t == 16);
      @(negedge clk);
    end
    seen  = '0;
    bad   = 0;
    ticks = 0;
    for (int c = 0; c < 10000; c++) begin
      if (rnd > 3'd5) bad++;
      seen[rnd] = 1'b1;
      if (tick === 1'b1) ticks++;
      @(negedge clk);
    end
    hits = $countones(seen);
    total++;
    if (bad != 0) $display("FAIL rand_range got %0d out-of-range want 0", bad);
    else passed++;
    total++;
    if (ticks != 1000) $display("FAIL tick_count got %0d want 1000", ticks);
    else passed++;
    total++;
    if (hits < 3 || seen[7:6] != 2'b00)
      $display("FAIL rand_spread got seen=%b want >=3 values in 0..5", seen);
    else passed++;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    pause = 1'b0;
    test_reset();
    test_single();
    test_simul();
    test_cooldown();
    test_pause();
    test_reset_gap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/care_scheduler.md
Name: care_scheduler

Overview:
Sequences the six tamagotchi care actions (feed, play, heal, clean, sleep, socialize) into the stats block's decrement-pulse bus (`inputs[7:0]`). It also generates the 1-second decay tick and the 0–5 random stat selector for that block. Care requests come from the button/menu layer. Requests are arbitrated round-robin and executed one at a time as a burst of spaced decrement pulses. A per-action cooldown then applies, measured in ticks.

Parameters:
- TICK_PERIOD, 27_000_000: clk cycles per decay tick (1 s at 27 MHz).
- STEPS, 4: decrement pulses issued per granted action (≥1).
- GAP_CYCLES, 2_700_000: cycles between consecutive pulses of one action (≥2).
- COOLDOWN_TICKS, 3: ticks an action stays blocked after completing (≥1).

Ports:
- clk  in  1  system clock, 27 MHz
- rst_n  in  1  asynchronous active-low reset
- req_i  in  6  one-cycle care request pulses; bit i maps to stat i (0 hunger … 5 social)
- pause_i  in  1  freezes tick/cooldown timing and new grants
- act_o  out  8  decrement pulses to stats `inputs`; bits 7:6 always 0
- tick_o  out  1  one-cycle decay tick
- rand_o  out  3  stat selector for decay, range 0–5
- busy_o  out  1  an action burst is in progress
- active_o  out  3  index of current or last granted action
- cooldown_o  out  6  per-action cooldown flags
- drop_o  out  1  one-cycle pulse when a request is rejected

Behaviour:
- Reset (async assert, sync release): all outputs 0; pending=0; all counters 0; LFSR=8'hA5; FSM=IDLE; round-robin pointer last=5, so index 0 has first priority.
- Pending register, updated every cycle:
  - pending[i] is set when req_i[i]=1 and the action is not in cooldown, not pending, and not active.
  - Otherwise a req_i[i] pulse produces drop_o=1 on the next cycle.
  - Requests are never lost while pause_i=1; they are held pending.
- FSM states: IDLE, APPLY, GAP.
  - IDLE: if pending≠0 and pause_i=0, grant the first set bit searching from (last+1) mod 6 upward with wrap. Then clear that pending bit, set last=active_o=index, step=0, and go to APPLY.
  - APPLY (1 cycle): act_o[active]=1, all other bits 0; step+=1. If step==STEPS: load cd_cnt[active]=COOLDOWN_TICKS and go to IDLE. Otherwise go to GAP.
  - GAP: wait GAP_CYCLES−1 cycles, then go to APPLY. Pulse-to-pulse spacing is exactly GAP_CYCLES.
  - busy_o=1 in APPLY and GAP.
  - pause_i does not stall APPLY or GAP; an in-progress burst always completes.
- Latency: a req pulse at cycle T with the FSM idle gives pending at T+1 and the first act_o pulse at T+2. Back-to-back grants leave exactly one IDLE cycle between the last pulse of one action and the first pulse of the next.
- Tick generator:
  - Counter runs 0..TICK_PERIOD−1 and wraps.
  - tick_o=1 for the cycle in which counter==TICK_PERIOD−1.
  - The counter holds while pause_i=1.
- Cooldown:
  - cd_cnt[i] (width to hold COOLDOWN_TICKS) decrements by 1 on each tick_o when nonzero.
  - cooldown_o[i]=(cd_cnt[i]≠0).
  - A load and a tick in the same cycle resolve as load wins.
- Random selector:
  - 8-bit Fibonacci LFSR, taps 8,6,5,4, shifts every cycle, never zero.
  - On each tick_o, rand_o is loaded with LFSR[2:0] mod 6 (6→0, 7→1); it holds between ticks.
- Simultaneous events:
  - Multiple req bits in one cycle are all accepted if eligible.
  - A req for the currently active index is dropped.
- Reset mid-burst: act_o returns to 0 immediately; the burst is not resumed.

Test Plan:
All scenarios use TICK_PERIOD=10, STEPS=3, GAP_CYCLES=4, COOLDOWN_TICKS=2.
1. Reset: assert rst_n=0, then release → act_o=0, tick_o=0, rand_o=0, cooldown_o=0, busy_o=0; first tick_o at cycle 10 after release.
2. Single request: req_i=6'b000001 at T → act_o=8'h01 at T+2, T+6, T+10 only; busy_o high T+2..T+10; cooldown_o[0]=1 from T+11 until the 2nd subsequent tick_o.
3. Simultaneous requests: req_i=6'b000110 after reset → grants index 1 (pulses T+2, T+6, T+10), then index 2 (pulses T+12, T+16, T+20); active_o 1 then 2.
4. Cooldown rejection: req_i[0] during its cooldown → drop_o=1 next cycle, no act_o[0] pulse; req_i[0] after cooldown clears → accepted normally.
5. Pause: pause_i=1 mid-burst → burst completes; tick_o stops; cooldown_o frozen; a new req stays pending; pause_i=0 → grant follows in the next IDLE cycle.
6. Reset during GAP: rst_n low between pulses 1 and 2 → act_o stays 0, pending and cooldown cleared; rand_o always in 0..5 across 1000 ticks.
